// File: rtl/serial_subtractor.sv
// serial_subtractor
// Digit-serial subtractor computing d = a - b - bin over WIDTH-bit operands,
// DIGIT bits per clock, least-significant digit first, with the borrow
// carried between digits in a register.
//
// Parameters:
//   WIDTH - operand/result width (multiple of DIGIT)
//   DIGIT - bits processed per clock (1..WIDTH)
//   SAT   - 1: a result that borrows out of the MSB is clamped to zero
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - operation request, sampled only while idle
//   a     - minuend, captured on the accepting edge
//   b     - subtrahend, captured on the accepting edge
//   bin   - borrow-in, captured on the accepting edge
//   busy  - high while an operation is in flight (RUN or DONE)
//   done  - one-cycle pulse when d/bout/zero/ovf carry a new result
//   d     - difference (after optional saturation)
//   bout  - borrow out of the MSB
//   zero  - d equals zero
//   ovf   - two's-complement overflow of the raw difference
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]       a_sh;
   logic [WIDTH-1:0]       b_sh;
   logic [WIDTH-1:0]       res_sh;
   logic                   borrow;
   logic [CW-1:0]          count;
   logic                   a_msb;
   logic                   b_msb;

   logic                   accept;
   logic                   last_step;
   logic [DIGIT:0]         dig_diff;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;
   logic                   sat_hit;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A start seen outside IDLE is simply not looked at,
   // which is what keeps a request during RUN/DONE from disturbing the
   // operation in flight. DONE always falls back to IDLE after one cycle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (count == LAST) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One digit of the subtraction. The DIGIT+1 bit result carries the
   // outgoing borrow in its top bit. The new digit enters the result
   // register from the MSB end, so after N steps digit 0 has travelled
   // down to the LSB position; concatenating and dropping the low DIGIT
   // bits also works when DIGIT == WIDTH.
   always_comb begin
      dig_diff = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                 - (DIGIT+1)'(borrow);
      res_cat  = {dig_diff[DIGIT-1:0], res_sh};
      res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
      sat_hit  = SAT && dig_diff[DIGIT];
   end

   // Datapath. Operand MSBs are kept separately because the shift
   // registers have lost them by the time overflow is evaluated. The
   // visible outputs are written only on the last RUN step, so they hold
   // steady through any later operation until its own completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         count  <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         d      <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         borrow <= bin;
         count  <= '0;
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_next;
         borrow <= dig_diff[DIGIT];
         count  <= count + CW'(1);
         if (last_step) begin
            bout <= dig_diff[DIGIT];
            ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            if (sat_hit) begin
               d    <= '0;
               zero <= 1'b1;
            end else begin
               d    <= res_next;
               zero <= (res_next == '0);
            end
         end
      end
   end

   // Status decodes come straight off the state register, so there is no
   // combinational path from any input to these outputs.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor. Six instances cover the widths of
// interest: 0: 1/1, 1: 16/4, 2: 16/4 saturating, 3: 8/1, 4: 32/8, 5: 16/16.
// Operations are issued to one instance at a time; expected results are
// queued at issue and a negedge monitor pops and compares on every done.
module tb_serial_subtractor;

   typedef struct {
      int          id;
      logic [31:0] d;
      logic        bout;
      logic        zero;
      logic        ovf;
   } expT;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;

   logic [5:0]  busyV;
   logic [5:0]  doneV;
   logic [5:0]  boutV;
   logic [5:0]  zeroV;
   logic [5:0]  ovfV;
   logic [31:0] dV [6];

   logic [0:0]  d0;
   logic [15:0] d1;
   logic [15:0] d2;
   logic [7:0]  d3;
   logic [31:0] d4;
   logic [15:0] d5;

   expT sbQueue[$];
   expT monEntry;
   int  checkCount = 0;
   int  failCount  = 0;
   int  cycle      = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   assign dV[0] = {31'd0, d0};
   assign dV[1] = {16'd0, d1};
   assign dV[2] = {16'd0, d2};
   assign dV[3] = {24'd0, d3};
   assign dV[4] = d4;
   assign dV[5] = {16'd0, d5};

   serial_subtractor #(.WIDTH(1), .DIGIT(1), .SAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a[0:0]), .b(b[0:0]), .bin(bin),
      .busy(busyV[0]), .done(doneV[0]), .d(d0), .bout(boutV[0]), .zero(zeroV[0]), .ovf(ovfV[0]));

   serial_subtractor #(.WIDTH(16), .DIGIT(4), .SAT(1'b0)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a[15:0]), .b(b[15:0]), .bin(bin),
      .busy(busyV[1]), .done(doneV[1]), .d(d1), .bout(boutV[1]), .zero(zeroV[1]), .ovf(ovfV[1]));

   serial_subtractor #(.WIDTH(16), .DIGIT(4), .SAT(1'b1)) dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .a(a[15:0]), .b(b[15:0]), .bin(bin),
      .busy(busyV[2]), .done(doneV[2]), .d(d2), .bout(boutV[2]), .zero(zeroV[2]), .ovf(ovfV[2]));

   serial_subtractor #(.WIDTH(8), .DIGIT(1), .SAT(1'b0)) dut3 (
      .clk(clk), .rst(rst), .start(start[3]), .a(a[7:0]), .b(b[7:0]), .bin(bin),
      .busy(busyV[3]), .done(doneV[3]), .d(d3), .bout(boutV[3]), .zero(zeroV[3]), .ovf(ovfV[3]));

   serial_subtractor #(.WIDTH(32), .DIGIT(8), .SAT(1'b0)) dut4 (
      .clk(clk), .rst(rst), .start(start[4]), .a(a), .b(b), .bin(bin),
      .busy(busyV[4]), .done(doneV[4]), .d(d4), .bout(boutV[4]), .zero(zeroV[4]), .ovf(ovfV[4]));

   serial_subtractor #(.WIDTH(16), .DIGIT(16), .SAT(1'b0)) dut5 (
      .clk(clk), .rst(rst), .start(start[5]), .a(a[15:0]), .b(b[15:0]), .bin(bin),
      .busy(busyV[5]), .done(doneV[5]), .d(d5), .bout(boutV[5]), .zero(zeroV[5]), .ovf(ovfV[5]));

   // Static description of each instance.
   function automatic int widthOf(input int id);
      case (id)
         0:       return 1;
         3:       return 8;
         4:       return 32;
         default: return 16;
      endcase
   endfunction

   function automatic int nOf(input int id);
      case (id)
         0:       return 1;
         3:       return 8;
         5:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic satOf(input int id);
      return (id == 2);
   endfunction

   // Reference model: plain integer subtraction reduced mod 2^W.
   function automatic expT model(input int id, input logic [31:0] aIn,
                                 input logic [31:0] bIn, input logic binIn);
      expT         e;
      int          w;
      longint      mask;
      longint      diff;
      logic [63:0] raw;
      w    = widthOf(id);
      mask = (longint'(1) << w) - 1;
      diff = (longint'(aIn) & mask) - (longint'(bIn) & mask) - longint'(binIn);
      raw  = 64'(diff & mask);
      e.id   = id;
      e.bout = (diff < 0);
      e.ovf  = (aIn[w-1] != bIn[w-1]) && (raw[w-1] != aIn[w-1]);
      e.d    = (satOf(id) && e.bout) ? 32'd0 : raw[31:0];
      e.zero = (e.d == 32'd0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: any done must correspond to a queued expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) begin
         if (doneV[i] === 1'b1) begin
            if (sbQueue.size() == 0) begin
               checkOutput($sformatf("spuriousDone%0d", i), 32'(doneV[i]), 32'd0);
            end else begin
               monEntry = sbQueue.pop_front();
               checkOutput("instance", i, monEntry.id);
               checkOutput($sformatf("d%0d", i), dV[i], monEntry.d);
               checkOutput($sformatf("bout%0d", i), 32'(boutV[i]), 32'(monEntry.bout));
               checkOutput($sformatf("zero%0d", i), 32'(zeroV[i]), 32'(monEntry.zero));
               checkOutput($sformatf("ovf%0d", i), 32'(ovfV[i]), 32'(monEntry.ovf));
            end
         end
      end
   end

   // Waits (bounded) for the next done of one instance.
   task automatic waitDone(input int id, output int doneCycle);
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (doneV[id] !== 1'b1 && guard < 200);
      if (guard >= 200) checkOutput("doneTimeout", 32'(doneV[id]), 32'd1);
      doneCycle = cycle;
   endtask

   // Issues one operation, queues its expected result, scrambles the inputs
   // after acceptance, then checks latency and that done is a single pulse.
   task automatic applyStimulus(input int id, input logic [31:0] aIn,
                                input logic [31:0] bIn, input logic binIn,
                                input logic [31:0] expD, input logic expBout,
                                input logic expZero, input logic expOvf);
      expT e;
      int  t0;
      int  tDone;
      @(negedge clk);
      a         = aIn;
      b         = bIn;
      bin       = binIn;
      start[id] = 1'b1;
      e.id = id; e.d = expD; e.bout = expBout; e.zero = expZero; e.ovf = expOvf;
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      t0        = cycle;
      start[id] = 1'b0;
      a         = $urandom;
      b         = $urandom;
      bin       = 1'($urandom_range(0, 1));
      waitDone(id, tDone);
      checkOutput($sformatf("latency%0d", id), tDone - t0, nOf(id));
      @(negedge clk);
      checkOutput($sformatf("donePulse%0d", id), 32'(doneV[id]), 32'd0);
   endtask

   task automatic applyRandom(input int id, input int count);
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbin;
      expT         e;
      for (int k = 0; k < count; k++) begin
         ra   = $urandom;
         rb   = $urandom;
         rbin = 1'($urandom_range(0, 1));
         e    = model(id, ra, rb, rbin);
         applyStimulus(id, ra, rb, rbin, e.d, e.bout, e.zero, e.ovf);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      int tA;
      int tB;
      int tC;
      int unused;
      rst   = 1'b1;
      start = '0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      #12;
      for (int i = 0; i < 6; i++) begin
         checkOutput("resetD", dV[i], 32'd0);
         checkOutput("resetBusy", 32'(busyV[i]), 32'd0);
         checkOutput("resetDone", 32'(doneV[i]), 32'd0);
         checkOutput("resetFlags", {29'd0, boutV[i], zeroV[i], ovfV[i]}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Full-subtractor truth table, WIDTH=1.
      applyStimulus(0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 32'd0, 32'd1, 1'b0, 32'd1, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 32'd0, 32'd1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
      applyStimulus(0, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);

      // Directed 16/4 vectors.
      applyStimulus(1, 32'h1234, 32'h0234, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1, 1'b0, 1'b0);
      applyStimulus(2, 32'h0000, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(2, 32'h1234, 32'h0234, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 32'h7FFF, 32'hFFFF, 1'b0, 32'h8000, 1'b1, 1'b0, 1'b1);
      applyStimulus(1, 32'h0005, 32'h0005, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1, 32'h0005, 32'h0005, 1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b0);

      // start pulsed mid-RUN with different operands must be ignored.
      @(negedge clk);
      a = 32'h1234; b = 32'h0234; bin = 1'b0; start[1] = 1'b1;
      sbQueue.push_back('{id: 1, d: 32'h1000, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
      @(posedge clk); #1 start[1] = 1'b0;
      @(posedge clk); #1 a = 32'hFFFF; b = 32'h0000; bin = 1'b1; start[1] = 1'b1;
      @(posedge clk); #1 start[1] = 1'b0;
      waitDone(1, unused);
      repeat (8) @(negedge clk);
      checkOutput("busyAfterIgnore", 32'(busyV[1]), 32'd0);
      checkOutput("dHeldAfterIgnore", dV[1], 32'h1000);

      // start held high: one acceptance every N+2 cycles.
      @(negedge clk);
      a = 32'h00F0; b = 32'h000F; bin = 1'b0; start[1] = 1'b1;
      for (int k = 0; k < 3; k++)
         sbQueue.push_back('{id: 1, d: 32'h00E1, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
      @(posedge clk); #1 t0 = cycle;
      waitDone(1, tA);
      waitDone(1, tB);
      waitDone(1, tC);
      start[1] = 1'b0;
      checkOutput("heldFirstLatency", tA - t0, 32'd4);
      checkOutput("heldInterval1", tB - tA, 32'd6);
      checkOutput("heldInterval2", tC - tB, 32'd6);
      repeat (8) @(negedge clk);

      // Reset at the second RUN edge aborts with no done.
      applyStimulus(1, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      a = 32'h4321; b = 32'h1111; bin = 1'b0; start[1] = 1'b1;
      @(posedge clk); #1 start[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abortD", dV[1], 32'd0);
      checkOutput("abortBusy", 32'(busyV[1]), 32'd0);
      checkOutput("abortDone", 32'(doneV[1]), 32'd0);
      checkOutput("abortFlags", {29'd0, boutV[1], zeroV[1], ovfV[1]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      applyStimulus(1, 32'h4321, 32'h1111, 1'b0, 32'h3210, 1'b0, 1'b0, 1'b0);

      // Random regression against the integer model.
      applyRandom(3, 200);
      applyRandom(1, 200);
      applyRandom(4, 200);
      applyRandom(5, 200);
      applyRandom(2, 100);

      repeat (4) @(negedge clk);
      checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
      $finish;
   end

endmodule
